// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types and constants.
// Frame FSM states, scancode prefixes and protocol byte classification.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    function automatic logic is_proto(input logic [7:0] b);
        return (b == 8'h00) || (b == PS2_BAT) ||
               (b == 8'hEE) || (b == PS2_ACK) ||
               (b == 8'hFC) || (b == 8'hFD) ||
               (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioner: 2-FF synchroniser then a glitch filter.
// The output flips only after FILTER consecutive differing samples.
module ps2_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    logic       sync1_q, sync2_q;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // count consecutive samples that disagree with the filtered level
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILTER - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // synchroniser, counter and filtered level; idle lines read high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: frames, prefix stripping, key events.
// Build with PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 56000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2ck,
    input  logic       ps2d,
    output logic       strb,
    output logic       make,
    output logic [7:0] code,
    output logic       ext,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic ck_f, d_f, ckp_q, fall;

    ps2_filter #(.FILTER(FILTER)) u_ck (
        .clock (clock),
        .reset (reset),
        .raw_i (ps2ck),
        .filt_o(ck_f)
    );

    ps2_filter #(.FILTER(FILTER)) u_d (
        .clock (clock),
        .reset (reset),
        .raw_i (ps2d),
        .filt_o(d_f)
    );

    assign fall = ckp_q & ~ck_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d;
    logic          xf_q, xf_d;
    logic [2:0]    skip_q, skip_d;
    logic          strb_q, strb_d;
    logic          make_q, make_d;
    logic [7:0]    code_q, code_d;
    logic          ext_q, ext_d;
    logic          err_q, err_d;
    logic          good, emit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic          rv_q, rv_d;
    logic          rx_q, rx_d;
    logic [7:0]    rc_q, rc_d;
    logic          hit;
`endif

    // frame FSM, timeout watchdog and byte decoder
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tmo_d   = '0;
        brk_d   = brk_q;
        xf_d    = xf_q;
        skip_d  = skip_q;
        strb_d  = 1'b0;
        make_d  = make_q;
        code_d  = code_q;
        ext_d   = ext_q;
        err_d   = 1'b0;
        good    = 1'b0;
        emit    = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        rv_d    = rv_q;
        rx_d    = rx_q;
        rc_d    = rc_q;
        hit     = rv_q && (rx_q == xf_q) && (rc_q == sh_q);
`endif
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!d_f) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    sh_d = {d_f, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = PARITY;
                    else               bit_d   = bit_q + 3'd1;
                end
                PARITY: begin
                    par_d   = d_f;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (d_f && (^{sh_q, par_q})) begin
                        good = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        brk_d  = 1'b0;
                        xf_d   = 1'b0;
                        skip_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                brk_d   = 1'b0;
                xf_d    = 1'b0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (good) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else if (sh_q == PS2_PAUSE) begin
                skip_d = PS2_PAUSE_SKIP;
            end else if (sh_q == PS2_EXT) begin
                xf_d = 1'b1;
            end else if (sh_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                xf_d  = 1'b0;
                emit  = !is_proto(sh_q);
            end
        end

        if (emit) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!brk_q) begin
                if (!hit) begin
                    strb_d = 1'b1;
                    rv_d   = 1'b1;
                    rx_d   = xf_q;
                    rc_d   = sh_q;
                end
            end else begin
                strb_d = 1'b1;
                if (hit) rv_d = 1'b0;
            end
`else
            strb_d = 1'b1;
`endif
        end

        if (strb_d) begin
            make_d = !brk_q;
            code_d = sh_q;
            ext_d  = xf_q;
        end
    end

    // state and registered event outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ckp_q   <= 1'b1;
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            brk_q   <= 1'b0;
            xf_q    <= 1'b0;
            skip_q  <= '0;
            strb_q  <= 1'b0;
            make_q  <= 1'b0;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ckp_q   <= ck_f;
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            brk_q   <= brk_d;
            xf_q    <= xf_d;
            skip_q  <= skip_d;
            strb_q  <= strb_d;
            make_q  <= make_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            err_q   <= err_d;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // last-pressed key record
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rv_q <= 1'b0;
            rx_q <= 1'b0;
            rc_q <= 8'h00;
        end else begin
            rv_q <= rv_d;
            rx_q <= rx_d;
            rc_q <= rc_d;
        end
    end
`endif

    assign strb = strb_q;
    assign make = make_q;
    assign code = code_q;
    assign ext  = ext_q;
    assign err  = err_q;

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard receiver that sits upstream of the zx core.
- Samples raw PS/2 clock and data lines and assembles 11-bit frames.
- Strips the E0, F0 and E1 prefixes and drops protocol bytes.
- Delivers one-cycle key events (strb/make/code/ext) that drive the core's keyboard strb/make/code inputs, all on the 56 MHz system clock.

Parameters:
- FILTER, 8: consecutive identical samples required before a filtered PS/2 line changes state (1..15).
- TIMEOUT, 56000: clock cycles without a falling PS/2 clock edge, inside a frame, before the frame is abandoned (1 ms at 56 MHz).

Ports:
- clock  in  1  system clock, 56 MHz.
- reset  in  1  asynchronous, active-low reset.
- ps2ck  in  1  raw PS/2 clock from the pad (pull-up external).
- ps2d   in  1  raw PS/2 data from the pad.
- strb   out 1  one-cycle key event strobe.
- make   out 1  1 = key press, 0 = key release; valid while strb is high.
- code   out 8  scancode (set 2); held until the next event.
- ext    out 1  scancode was preceded by E0; held until the next event.
- err    out 1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset: strb=0, make=0, code=8'h00, ext=0, err=0. FSM returns to IDLE; prefix flags, skip counter and timeout counter clear. Filtered lines reset to 1.
- Input path:
  - Each line passes a 2-FF synchroniser, then the glitch filter.
  - The filtered output toggles only after FILTER consecutive samples differ from its current value.
  - fall = filtered clock was 1 last cycle and is 0 now.
- FSM (all transitions are on fall only, except timeout):
  - IDLE: if data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE; this is not an error.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: frame is good if stop=1 and the XOR of 8 data bits plus parity is 1 (odd parity). Good or bad, return to IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and clears on fall.
  - On reaching TIMEOUT-1: return to IDLE, pulse err, clear prefixes.
  - Reset mid-frame abandons the frame silently.
- Bad frame: err=1 for one cycle, 1 cycle after the STOP fall. Byte is discarded; brk, ext and skip all clear.
- Good frame byte decode, applied 1 cycle after the STOP fall:
  - skip counter nonzero: decrement, drop byte.
  - E1: skip=7, which drops the rest of the 8-byte Pause sequence; no event.
  - E0: set ext flag.
  - F0: set brk flag.
  - 00, AA, EE, FA, FC, FD, FE, FF: dropped; prefixes clear.
  - Any other byte: strb=1 for exactly one cycle, with make=!brk, code=byte, ext=ext flag. Both flags then clear.
- Latency: strb is registered and rises on the clock edge after the cycle in which the STOP fall is detected. Only one event is produced per frame. The next frame cannot complete within FILTER+1 cycles, so events never overlap.
- The decoder is driven by good-frame completion and timeout only; there are no simultaneous-event cases. If a timeout and a fall arrive in the same cycle, the fall wins and the counter clears.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Holds a "last pressed" record {valid, ext, code}.
  - A make event equal to the record is suppressed (no strb).
  - A make event that differs is emitted and replaces the record.
  - A break event matching the record emits and invalidates it.
  - A break event for a different key emits and leaves the record unchanged.
- Undefined: every typematic repeat produces a make strobe. There is no record logic and no extra flops.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA.
  - PS2_PAUSE_SKIP=7.
- One sub-module, ps2_filter (synchroniser plus FILTER-count glitch filter, parameter FILTER). It is instantiated once for ps2ck and once for ps2d.

Test Plan:
- Frame 1C with parity 0, stop 1, at a 12.5 kHz PS/2 clock -> one strb with make=1, code=1C, ext=0; err stays 0.
- Sequence F0,1C -> no strb on F0, then strb with make=0, code=1C.
- Sequence E0,F0,75 -> single strb with make=0, ext=1, code=75. A following frame 75 -> ext=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C -> exactly one strb (code=1C).
- Error cases:
  - 1C with parity 1 -> err pulse, no strb.
  - Start plus 3 bits, then the clock held high for 56000 cycles -> err pulse, FSM in IDLE. The next good frame 29 -> strb with code=29.
  - 2-cycle glitches on ps2ck -> ignored.
- With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C -> one make strobe and one break strobe. Without it: three make strobes and one break strobe.
